// File: rtl/full_subtractor_b_if.sv
// rtl/full_subtractor_b_if.sv - operand/result bundle for the registered full subtractor
interface full_subtractor_b_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic [WIDTH-1:0] d;
    logic             borrow_out;

    modport master (
        output a,
        output b,
        output borrow_in,
        input  d,
        input  borrow_out
    );

    modport slave (
        input  a,
        input  b,
        input  borrow_in,
        output d,
        output borrow_out
    );
endinterface

// File: rtl/full_subtractor_b.sv
// rtl/full_subtractor_b.sv - ripple-borrow subtractor with one-cycle registered result
module full_subtractor_b #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    full_subtractor_b_if.slave   bus
);
    logic [WIDTH-1:0] d_d;
    logic [WIDTH-1:0] d_q;
    logic             borrow_out_d;
    logic             borrow_out_q;

    // Borrow ripples LSB to MSB; br is a blocking scratch variable so no combinational vector loop forms.
    always_comb begin : sub_chain
        logic br;
        br           = bus.borrow_in;
        d_d          = '0;
        borrow_out_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            d_d[i] = bus.a[i] ^ bus.b[i] ^ br;
            br     = (~bus.a[i] & bus.b[i]) | (~(bus.a[i] ^ bus.b[i]) & br);
        end
        borrow_out_d = br;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q          <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            d_q          <= d_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign bus.d          = d_q;
    assign bus.borrow_out = borrow_out_q;
endmodule

// File: tb/tb_full_subtractor_b.sv
// tb/tb_full_subtractor_b.sv - scoreboard bench for 1-bit and 8-bit subtractor instances
module tb_full_subtractor_b;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    full_subtractor_b_if #(.WIDTH(1)) if1 ();
    full_subtractor_b_if #(.WIDTH(8)) if8 ();

    full_subtractor_b #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    full_subtractor_b #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    typedef struct {
        logic [7:0] d8;
        logic       bo8;
        logic       d1;
        logic       bo1;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-written WIDTH=1 truth table indexed by {a,b,bin}, entries are {d,bout}.
    logic [1:0] tt [8];
    initial begin
        tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
        tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic r, input bit glitch, input bit hand,
                         input logic [8:0] hand_exp, input int tag);
        exp_t       e;
        logic [8:0] m8;
        logic [1:0] m1;
        @(negedge clk);
        if8.a = a;  if8.b = b;  if8.borrow_in = bin;
        if1.a = a[0]; if1.b = b[0]; if1.borrow_in = bin;
        rst = r;
        m8 = hand ? hand_exp : ({1'b0, a} - {1'b0, b} - {8'd0, bin});
        m1 = tt[{a[0], b[0], bin}];
        e.d8  = r ? 8'h00 : m8[7:0];
        e.bo8 = r ? 1'b0  : m8[8];
        e.d1  = r ? 1'b0  : m1[1];
        e.bo1 = r ? 1'b0  : m1[0];
        e.tag = tag;
        sb.push_back(e);
        if (glitch) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({if1.borrow_out, if1.d} !== {e.bo1, e.d1}) begin
                errors++;
                $display("FAIL w1 tag=%0d got bo,d=%b%b want %b%b", e.tag,
                         if1.borrow_out, if1.d, e.bo1, e.d1);
            end
            checks++;
            if ({if8.borrow_out, if8.d} !== {e.bo8, e.d8}) begin
                errors++;
                $display("FAIL w8 tag=%0d got bo=%b d=%h want bo=%b d=%h", e.tag,
                         if8.borrow_out, if8.d, e.bo8, e.d8);
            end
        end
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        if1.a = '0; if1.b = '0; if1.borrow_in = 1'b0;
        if8.a = '0; if8.b = '0; if8.borrow_in = 1'b0;

        // reset held with a=1,b=0,bin=0, then release
        drive(8'h01, 8'h00, 1'b0, 1'b1, 0, 0, 9'd0, 1);
        drive(8'h01, 8'h00, 1'b0, 1'b1, 0, 0, 9'd0, 2);
        drive(8'h01, 8'h00, 1'b0, 1'b0, 0, 0, 9'd0, 3);

        // exhaustive 1-bit table, each vector held two clocks
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 2; k++)
                drive({7'd0, v[2]}, {7'd0, v[1]}, v[0], 1'b0, 0, 0, 9'd0, 100 + v);
        end

        // back-to-back latency: 011 then 100
        drive(8'h00, 8'h01, 1'b1, 1'b0, 0, 0, 9'd0, 200);
        drive(8'h01, 8'h00, 1'b0, 1'b0, 0, 0, 9'd0, 201);

        // mid-stream reset while streaming 111
        for (int k = 0; k < 3; k++) drive(8'h01, 8'h01, 1'b1, 1'b0, 0, 0, 9'd0, 300);
        drive(8'h01, 8'h01, 1'b1, 1'b1, 0, 0, 9'd0, 301);
        for (int k = 0; k < 2; k++) drive(8'h01, 8'h01, 1'b1, 1'b0, 0, 0, 9'd0, 302);

        // short rst pulse between edges must not disturb outputs
        drive(8'h01, 8'h00, 1'b0, 1'b0, 1, 0, 9'd0, 400);
        drive(8'h01, 8'h01, 1'b1, 1'b0, 1, 0, 9'd0, 401);

        // 8-bit directed vectors with hand-computed results
        drive(8'h00, 8'hFF, 1'b1, 1'b0, 0, 1, {1'b1, 8'h00}, 500);
        drive(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1, {1'b0, 8'h1E}, 501);
        drive(8'h37, 8'h37, 1'b1, 1'b0, 0, 1, {1'b1, 8'hFF}, 502);
        drive(8'hFF, 8'h00, 1'b0, 1'b0, 0, 1, {1'b0, 8'hFF}, 503);
        drive(8'h80, 8'h01, 1'b0, 1'b0, 0, 1, {1'b0, 8'h7F}, 504);
        drive(8'h10, 8'h20, 1'b1, 1'b0, 0, 1, {1'b1, 8'hEF}, 505);

        // random back-to-back stream
        for (int k = 0; k < 1000; k++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            drive(ra, rb, rbin, 1'b0, 0, 0, 9'd0, 1000 + k);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
